// File: rtl/sgd_x_wb_pkg.sv
// sgd_x_wb_pkg: shared constants and the writeback state encoding.
package sgd_x_wb_pkg;

    localparam int CHUNK          = 512;
    localparam int LINE_BYTES     = 64;
    localparam int LINES_PER_BANK = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/sgd_x_wb_addr_gen.sv
// sgd_x_wb_addr_gen: latches the per-run chunk count and epoch size, and
// accumulates the host address of the current epoch image.
module sgd_x_wb_addr_gen #(
    parameter int ENGINE_NUM        = 8,
    parameter int NUM_BITS_PER_BANK = 64,
    parameter int LINES             = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        latch,
    input  logic        advance,
    input  logic [31:0] dimension,
    input  logic [63:0] addr_model,
    output logic [31:0] chunks,
    output logic [31:0] epoch_bytes,
    output logic [63:0] epoch_addr
);
    import sgd_x_wb_pkg::*;

    localparam int CHUNK_LOG = $clog2(ENGINE_NUM * NUM_BITS_PER_BANK);

    logic [32:0] dim_round;
    logic [31:0] chunks_raw;
    logic [31:0] lines_per_epoch;

    // 33-bit round-up so a dimension near 2^32 cannot wrap to zero chunks
    assign dim_round       = {1'b0, dimension} + 33'(ENGINE_NUM * NUM_BITS_PER_BANK - 1);
    assign chunks_raw      = 32'(dim_round >> CHUNK_LOG);
    assign lines_per_epoch = chunks * 32'(ENGINE_NUM * LINES);
    assign epoch_bytes     = lines_per_epoch * 32'(LINE_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            chunks     <= '0;
            epoch_addr <= '0;
        end else if (latch) begin
            chunks     <= chunks_raw == '0 ? 32'd1 : chunks_raw;
            epoch_addr <= addr_model;
        end else if (advance) begin
            epoch_addr <= epoch_addr + {32'd0, epoch_bytes};
        end
    end

endmodule

// File: rtl/sgd_x_host_writeback.sv
// sgd_x_host_writeback: drains the per-engine x-model FIFOs and streams each
// epoch to host memory as one write command followed by engine-major lines.
module sgd_x_host_writeback #(
    parameter int ENGINE_NUM        = 8,
    parameter int NUM_BITS_PER_BANK = 64,
    parameter int LINES_PER_BANK    = NUM_BITS_PER_BANK * 32 / 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         started,
    input  logic [63:0]                  addr_model,
    input  logic [31:0]                  dimension,
    input  logic [31:0]                  numEpochs,
    input  logic [ENGINE_NUM-1:0][511:0] x_to_mem_rd_data,
    input  logic [ENGINE_NUM-1:0]        x_to_mem_empty,
    output logic [ENGINE_NUM-1:0]        x_to_mem_rd_en,
    output logic                         x_data_send_back_start,
    output logic [63:0]                  x_data_send_back_addr,
    output logic [31:0]                  x_data_send_back_length,
    output logic [511:0]                 x_data_out,
    output logic                         x_data_out_valid,
    input  logic                         x_data_out_almost_full,
    output logic                         writeback_done,
    output logic [31:0]                  x_mem_cmd_cnt,
    output logic [31:0]                  x_mem_data_cnt
);
    import sgd_x_wb_pkg::*;

    localparam int EW = ENGINE_NUM > 1 ? $clog2(ENGINE_NUM) : 1;
    localparam int LW = LINES_PER_BANK > 1 ? $clog2(LINES_PER_BANK) : 1;

    state_t        state, next_state;
    logic          started_q, rise, pop;
    logic          last_line, last_engine, last_chunk, last_pop;
    logic [EW-1:0] engine_idx;
    logic [LW-1:0] line_idx;
    logic [31:0]   chunk_idx, epoch_idx, epochs, chunks, epoch_bytes;
    logic [63:0]   epoch_addr;

    assign rise        = started & ~started_q;
    assign last_line   = line_idx == LW'(LINES_PER_BANK - 1);
    assign last_engine = engine_idx == EW'(ENGINE_NUM - 1);
    assign last_chunk  = chunk_idx == chunks - 32'd1;
    // almost_full's two-entry margin absorbs the output register, so it gates the pop directly
    assign pop         = state == DATA & ~x_to_mem_empty[engine_idx] & ~x_data_out_almost_full;
    assign last_pop    = pop & last_line & last_engine & last_chunk;

    sgd_x_wb_addr_gen #(
        .ENGINE_NUM       (ENGINE_NUM),
        .NUM_BITS_PER_BANK(NUM_BITS_PER_BANK),
        .LINES            (LINES_PER_BANK)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .latch      (state == IDLE & rise),
        .advance    (state == NEXT),
        .dimension  (dimension),
        .addr_model (addr_model),
        .chunks     (chunks),
        .epoch_bytes(epoch_bytes),
        .epoch_addr (epoch_addr)
    );

    always_comb begin
        next_state = state;
        x_to_mem_rd_en = '0;
        x_to_mem_rd_en[engine_idx] = pop;
        case (state)
            IDLE:    next_state = rise && numEpochs != '0 ? CMD : IDLE;
            CMD:     next_state = DATA;
            DATA:    next_state = last_pop ? NEXT : DATA;
            NEXT:    next_state = epoch_idx + 32'd1 == epochs ? DONE : CMD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            started_q               <= 1'b0;
            engine_idx              <= '0;
            line_idx                <= '0;
            chunk_idx               <= '0;
            epoch_idx               <= '0;
            epochs                  <= '0;
            x_data_send_back_start  <= 1'b0;
            x_data_send_back_addr   <= '0;
            x_data_send_back_length <= '0;
            x_data_out              <= '0;
            x_data_out_valid        <= 1'b0;
            writeback_done          <= 1'b0;
            x_mem_cmd_cnt           <= '0;
            x_mem_data_cnt          <= '0;
        end else begin
            state     <= next_state;
            started_q <= started;
            if (state == IDLE && rise) begin
                epochs    <= numEpochs;
                epoch_idx <= '0;
            end
            if (state == NEXT)
                epoch_idx <= epoch_idx + 32'd1;
            // indices wrap back to zero on the final pop, ready for the next epoch
            if (pop) begin
                line_idx <= last_line ? '0 : line_idx + LW'(1);
                if (last_line)
                    engine_idx <= last_engine ? '0 : engine_idx + EW'(1);
                if (last_line && last_engine)
                    chunk_idx <= last_chunk ? '0 : chunk_idx + 32'd1;
            end
            x_data_send_back_start <= state == CMD;
            if (state == CMD) begin
                x_data_send_back_addr   <= epoch_addr;
                x_data_send_back_length <= epoch_bytes;
            end
            x_data_out_valid <= pop;
            if (pop)
                x_data_out <= x_to_mem_rd_data[engine_idx];
            writeback_done <= state == DONE || (state == IDLE && rise && numEpochs == '0);
            x_mem_cmd_cnt  <= x_mem_cmd_cnt + 32'(x_data_send_back_start);
            x_mem_data_cnt <= x_mem_data_cnt + 32'(x_data_out_valid);
        end
    end

endmodule
